audio_output_fifo: RTL and testbench

AUDIO_OUTPUT_FIFO -- requirements
Module: audio_output_fifo

---
 rtl/audio_output_fifo.sv | 171 +++++++++++++++++
 tb/tb_audio_output_fifo.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_output_fifo.sv
// rtl/audio_output_fifo.sv - Dual-channel audio output FIFO with priming, rate pacing and underrun handling
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_sample/in_write    decoder sample and write request (held until in_strobe)
//   in_strobe             single-cycle accept pulse
//   in_channel            0 = left, 1 = right (stereo only)
//   in_coding             header coding byte: [1:0] chan (01 = stereo, else mono),
//                         [3:2] rate (01 = 18.9 kHz, else 37.8 kHz)
//   sample_tick           37.8 kHz output-rate strobe
//   flush                 discard all buffered audio
//   out_left/out_right    current stereo output pair
//   out_valid             a new output pair was presented
//   underrun              starved pop tick while running
//   level                 left FIFO occupancy, 0..DEPTH
module audio_output_fifo #(
    parameter int DEPTH = 16,
    parameter int PRIME = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [15:0]              in_sample,
    input  logic                     in_write,
    output logic                     in_strobe,
    input  logic                     in_channel,
    input  logic [7:0]               in_coding,
    input  logic                     sample_tick,
    input  logic                     flush,
    output logic [15:0]              out_left,
    output logic [15:0]              out_right,
    output logic                     out_valid,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {FILL, RUN} state_t;

    logic [15:0]   mem_l [DEPTH];
    logic [15:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_l_q, wr_r_q, rd_l_q, rd_r_q;
    logic [CW-1:0] count_l_q, count_r_q, count_l_d, count_r_d;
    state_t        state_q;
    logic          phase_q;
    logic          rate18_q;
    logic          in_strobe_q;
    logic          out_valid_q;
    logic          underrun_q;
    logic [15:0]   out_left_q, out_right_q;

    logic coding_stereo, coding_rate18;
    logic room_l, room_r, room, accept, push_l, push_r;
    logic tick_v, run_tick, pop_tick, both_ne, pop, starve;
    logic unused_coding;

    assign coding_stereo = (in_coding[1:0] == 2'b01);
    assign coding_rate18 = (in_coding[3:2] == 2'b01);
    assign unused_coding = ^in_coding[7:4];

    // DEPTH is a power of two, so the count MSB alone marks "full".
    assign room_l = ~count_l_q[AW];
    assign room_r = ~count_r_q[AW];
    assign room   = coding_stereo ? (in_channel ? room_r : room_l) : (room_l & room_r);

    // A flush frees all space, so a pending write is still acknowledged
    // (and its data discarded) to keep the decoder moving.
    assign accept = in_write & ~in_strobe_q & (room | flush);
    assign push_l = accept & ~flush & (~coding_stereo | ~in_channel);
    assign push_r = accept & ~flush & (~coding_stereo |  in_channel);

    assign tick_v   = sample_tick & ~flush;
    assign run_tick = tick_v & (state_q == RUN);
    assign pop_tick = run_tick & (~rate18_q | ~phase_q);
    assign both_ne  = (count_l_q != '0) & (count_r_q != '0);
    // Both channels pop together or not at all to keep L/R aligned.
    assign pop      = pop_tick & both_ne;
    assign starve   = pop_tick & ~both_ne;

    always_comb begin
        count_l_d = count_l_q;
        if (push_l && !pop)      count_l_d = count_l_q + CW'(1);
        else if (!push_l && pop) count_l_d = count_l_q - CW'(1);
        count_r_d = count_r_q;
        if (push_r && !pop)      count_r_d = count_r_q + CW'(1);
        else if (!push_r && pop) count_r_d = count_r_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset && push_l) mem_l[wr_l_q] <= in_sample;
        if (!reset && push_r) mem_r[wr_r_q] <= in_sample;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_l_q      <= '0;
            wr_r_q      <= '0;
            rd_l_q      <= '0;
            rd_r_q      <= '0;
            count_l_q   <= '0;
            count_r_q   <= '0;
            state_q     <= FILL;
            phase_q     <= 1'b0;
            rate18_q    <= 1'b0;
            in_strobe_q <= 1'b0;
            out_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
            out_left_q  <= '0;
            out_right_q <= '0;
        end else if (flush) begin
            wr_l_q      <= '0;
            wr_r_q      <= '0;
            rd_l_q      <= '0;
            rd_r_q      <= '0;
            count_l_q   <= '0;
            count_r_q   <= '0;
            state_q     <= FILL;
            phase_q     <= 1'b0;
            in_strobe_q <= accept;
            out_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
            out_left_q  <= '0;
            out_right_q <= '0;
        end else begin
            in_strobe_q <= accept;
            count_l_q   <= count_l_d;
            count_r_q   <= count_r_d;
            out_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
            if (push_l) wr_l_q <= wr_l_q + AW'(1);
            if (push_r) wr_r_q <= wr_r_q + AW'(1);
            if (push_l || push_r) rate18_q <= coding_rate18;
            case (state_q)
                FILL: begin
                    if (count_l_q >= CW'(PRIME) && count_r_q >= CW'(PRIME)) begin
                        state_q <= RUN;
                        phase_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (run_tick) begin
                        phase_q <= ~phase_q;
                        if (pop) begin
                            out_left_q  <= mem_l[rd_l_q];
                            out_right_q <= mem_r[rd_r_q];
                            rd_l_q      <= rd_l_q + AW'(1);
                            rd_r_q      <= rd_r_q + AW'(1);
                            out_valid_q <= 1'b1;
                        end else if (starve) begin
                            underrun_q <= 1'b1;
                            state_q    <= FILL;
                        end else begin
                            // 18.9 kHz repeat: re-present the held pair.
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign in_strobe = in_strobe_q;
    assign out_valid = out_valid_q;
    assign underrun  = underrun_q;
    assign out_left  = out_left_q;
    assign out_right = out_right_q;
    assign level     = count_l_q;

endmodule

// File: tb/tb_audio_output_fifo.sv
// tb/tb_audio_output_fifo.sv - Scoreboard testbench for audio_output_fifo
module tb_audio_output_fifo;

    localparam logic [7:0] ST37 = 8'h01;
    localparam logic [7:0] MO37 = 8'h00;
    localparam logic [7:0] MO18 = 8'h04;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_sample;
    logic        in_write;
    logic        in_strobe;
    logic        in_channel;
    logic [7:0]  in_coding;
    logic        sample_tick;
    logic        flush;
    logic [15:0] out_left, out_right;
    logic        out_valid, underrun;
    logic [4:0]  level;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        under;
        logic [15:0] l;
        logic [15:0] r;
    } ev_t;
    ev_t exp_q[$];
    ev_t mon_e;

    audio_output_fifo #(.DEPTH(16), .PRIME(4)) dut (
        .clk(clk), .reset(reset), .in_sample(in_sample), .in_write(in_write),
        .in_strobe(in_strobe), .in_channel(in_channel), .in_coding(in_coding),
        .sample_tick(sample_tick), .flush(flush), .out_left(out_left),
        .out_right(out_right), .out_valid(out_valid), .underrun(underrun),
        .level(level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic expect_pair(input logic under, input logic [15:0] l, input logic [15:0] r);
        ev_t e;
        e.under = under;
        e.l = l;
        e.r = r;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [15:0] s, input logic ch, input logic [7:0] cod);
        int n;
        n = 0;
        @(negedge clk);
        in_sample  = s;
        in_channel = ch;
        in_coding  = cod;
        in_write   = 1'b1;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!in_strobe && n < 50);
        checks++;
        if (!in_strobe) begin
            errors++;
            $display("FAIL push_timeout actual=no_strobe required=strobe sample=%0d", s);
        end
        in_write = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    // Monitor: every presented output event is matched against the scoreboard.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid actual=(%0d,%0d) required=none",
                         $signed(out_left), $signed(out_right));
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.under || out_left !== mon_e.l || out_right !== mon_e.r) begin
                    errors++;
                    $display("FAIL out_pair actual=valid(%0d,%0d) required=%s(%0d,%0d)",
                             $signed(out_left), $signed(out_right),
                             mon_e.under ? "underrun" : "valid",
                             $signed(mon_e.l), $signed(mon_e.r));
                end
            end
        end
        if (!reset && underrun) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_underrun actual=underrun required=none");
            end else begin
                mon_e = exp_q.pop_front();
                if (!mon_e.under || out_left !== mon_e.l || out_right !== mon_e.r) begin
                    errors++;
                    $display("FAIL underrun_event actual=underrun(%0d,%0d) required=%s(%0d,%0d)",
                             $signed(out_left), $signed(out_right),
                             mon_e.under ? "underrun" : "valid",
                             $signed(mon_e.l), $signed(mon_e.r));
                end
            end
        end
    end

    initial begin
        reset = 1'b1; in_sample = '0; in_write = 1'b0; in_channel = 1'b0;
        in_coding = ST37; sample_tick = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_level", level, 0);
        chk("reset_strobe", in_strobe, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_underrun", underrun, 0);
        chk("reset_left", out_left, 0);
        chk("reset_right", out_right, 0);
        @(negedge clk);
        reset = 1'b0;

        // Stereo 37.8 kHz, then a starved fifth tick.
        for (int i = 0; i < 4; i++) begin
            push((i % 2) ? 16'd200 : 16'd100, 1'b0, ST37);
            push((i % 2) ? 16'hFF38 : 16'hFF9C, 1'b1, ST37);
        end
        chk("stereo_level", level, 4);
        idle(2);
        for (int i = 0; i < 4; i++)
            expect_pair(1'b0, (i % 2) ? 16'd200 : 16'd100, (i % 2) ? 16'hFF38 : 16'hFF9C);
        expect_pair(1'b1, 16'd200, 16'hFF38);
        for (int i = 0; i < 5; i++) begin
            tick();
            idle(1);
        end
        idle(3);
        chk("underrun_level", level, 0);
        chk("underrun_hold_left", out_left, 200);

        // Mono 18.9 kHz: each popped pair is presented twice.
        push(16'd10, 1'b0, MO18);
        push(16'd20, 1'b0, MO18);
        push(16'd30, 1'b0, MO18);
        push(16'd40, 1'b0, MO18);
        chk("mono_level", level, 4);
        idle(2);
        expect_pair(1'b0, 16'd10, 16'd10);
        expect_pair(1'b0, 16'd10, 16'd10);
        expect_pair(1'b0, 16'd20, 16'd20);
        expect_pair(1'b0, 16'd20, 16'd20);
        for (int i = 0; i < 4; i++) tick();
        idle(3);
        chk("mono_level_after", level, 2);
        do_flush();
        chk("flush_level", level, 0);
        chk("flush_left", out_left, 0);

        // Full back-pressure on the left FIFO.
        for (int i = 0; i < 16; i++) push(16'(1000 + i), 1'b0, ST37);
        chk("full_level", level, 16);
        @(negedge clk);
        in_sample = 16'd2000; in_channel = 1'b0; in_coding = ST37; in_write = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("full_no_strobe", in_strobe, 0);
        end
        chk("full_level_held", level, 16);
        @(negedge clk);
        in_write = 1'b0;
        for (int i = 0; i < 4; i++) push(16'(-1 - i), 1'b1, ST37);
        idle(2);
        expect_pair(1'b0, 16'd1000, 16'hFFFF);
        tick();
        push(16'd2000, 1'b0, ST37);
        idle(1);
        chk("full_level_refill", level, 16);
        do_flush();

        // Flush coinciding with tick and push.
        for (int i = 1; i <= 9; i++) push(16'(i), 1'b0, MO37);
        idle(2);
        expect_pair(1'b0, 16'd1, 16'd1);
        tick();
        idle(2);
        chk("pre_flush_level", level, 8);
        @(negedge clk);
        in_sample = 16'd555; in_channel = 1'b0; in_coding = MO37;
        in_write = 1'b1; flush = 1'b1; sample_tick = 1'b1;
        @(posedge clk);
        #1;
        chk("coinc_level", level, 0);
        chk("coinc_left", out_left, 0);
        chk("coinc_right", out_right, 0);
        chk("coinc_valid", out_valid, 0);
        chk("coinc_strobe", in_strobe, 1);
        flush = 1'b0; sample_tick = 1'b0; in_write = 1'b0;
        @(posedge clk);
        #1;
        chk("coinc_strobe_once", in_strobe, 0);
        chk("coinc_push_dropped", level, 0);

        // Reset with a pending write and half-full FIFOs.
        for (int i = 0; i < 9; i++) push(16'(50 + i), 1'b0, MO37);
        idle(2);
        expect_pair(1'b0, 16'd50, 16'd50);
        tick();
        idle(2);
        chk("pre_reset_level", level, 8);
        chk("pre_reset_left", out_left, 50);
        @(negedge clk);
        in_sample = 16'd77; in_write = 1'b1; reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_strobe_0", in_strobe, 0);
        chk("rst_level", level, 0);
        chk("rst_left", out_left, 0);
        chk("rst_right", out_right, 0);
        @(posedge clk);
        #1;
        chk("rst_strobe_1", in_strobe, 0);
        @(negedge clk);
        in_write = 1'b0; reset = 1'b0;
        idle(4);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
